muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer and HI/LO register owner for the MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the decode/execute stage.
- Runs a radix-2 shift-add multiply or restoring divide over 32 cycles, then applies sign correction.
- Stalls the pipeline via `busy` and exposes HI/LO for MFHI/MFLO reads.

Parameters:
- XLEN, 32, operand and HI/LO width; iteration count equals XLEN.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request valid for one cycle; sampled only in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (ignored).
- src_a  in  XLEN  rs value (multiplicand/dividend/MT source).
- src_b  in  XLEN  rt value (multiplier/divisor).
- busy  out  1  high while an operation is in flight; the pipeline stalls on it.
- done  out  1  one-cycle pulse when HI/LO take a mult/div result.
- div_zero  out  1  pulse coincident with `done` when the divisor was 0.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset, sampled at a rising edge with rst_n=0:
  - state goes to IDLE.
  - hi, lo, busy, done, div_zero, iteration counter and internal accumulators all go to 0.
  - Reset mid-operation abandons the operation; no done pulse and no HI/LO update.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start=1 with MTHI: hi<=src_a at that edge; no busy, no done.
  - start=1 with MTLO: lo<=src_a at that edge; no busy, no done.
  - start=1 with MULT/MULTU: latch operand magnitudes (signed ops take absolute values), record result signs, count<=0, go to MUL.
  - start=1 with DIV/DIVU: same latching as multiply, go to DIV.
  - Reserved op: ignored.
  - start=0: stay in IDLE.
- MUL:
  - One shift-add step per cycle on a 2*XLEN product register.
  - After XLEN steps (count==XLEN-1), go to FIX.
- DIV:
  - One restoring step per cycle; remainder is XLEN+1 bits.
  - After XLEN steps, go to FIX.
  - Divisor==0: skip iteration and go straight from IDLE to FIX.
- FIX, one cycle, then back to IDLE:
  - Multiply: negate the 64-bit product if signs differed; hi/lo <= product[63:32]/[31:0].
  - Divide: quotient negated if signs differed, remainder takes the sign of the dividend; lo<=quotient, hi<=remainder.
- Timing: busy is high in MUL, DIV and FIX. done (and div_zero) are registered and high exactly one cycle, the cycle after FIX. hi/lo are visible the same cycle done is high.
- Latency, start accepted at edge E0:
  - mult/div, nonzero divisor: done high during cycle after edge E0+XLEN+1; 34 cycles for XLEN=32.
  - Divide by zero: done high after E0+1; lo=32'hFFFFFFFF, hi=src_a, div_zero=1.
- Arithmetic rules:
  - Signed divide truncates toward zero.
  - 0x80000000 / -1 yields lo=0x80000000, hi=0.
  - Unsigned ops never negate.
- start while busy is ignored: no queueing, no effect on the in-flight op. The pipeline must hold the instruction while busy.
- start in the same cycle that done is high is accepted normally, since state is IDLE.
- Operands are latched at acceptance; src_a/src_b changes during busy have no effect.

Optional Feature:
- Macro: MULDIV_FAST_ZERO_EN.
- Defined: MULT/MULTU with src_a==0 or src_b==0 goes from IDLE straight to FIX. hi=lo=0, done after E0+1, exactly as the divide-by-zero path.
- Undefined: such operands take the full XLEN+1 cycle path; result is identical, only latency differs.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-MULT -> hi=lo=0, busy=0, no done pulse afterwards.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> after 34 cycles, done=1, hi=0xFFFFFFFE, lo=0x00000001. MULT -3 * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 5 / 0 -> done two cycles after start, div_zero=1, lo=0xFFFFFFFF, hi=5, busy high exactly 1 cycle.
- MTHI 0x1234 then MTLO 0x5678 in consecutive cycles -> hi=0x1234, lo=0x5678, busy never high. start MULT during busy -> ignored; original result intact.
- With MULDIV_FAST_ZERO_EN: MULT 0 * 0x55 -> done two cycles after start, hi=lo=0. Without it: done at 34 cycles, same values.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// Optional `MULDIV_FAST_ZERO_EN: multiplies with a zero operand skip iteration.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  // Handshake: start is a one-cycle request taken only while busy=0. There is
  // no queueing, so the pipeline must hold the instruction until busy drops.
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic              neg_q;
  logic              neg_r;
  logic              is_div;
  logic              dz;

  logic              op_signed;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              fast_zero;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  assign op_signed = ~op[0];
  assign abs_a     = (op_signed && src_a[XLEN-1]) ? -src_a : src_a;
  assign abs_b     = (op_signed && src_b[XLEN-1]) ? -src_b : src_b;

`ifdef MULDIV_FAST_ZERO_EN
  assign fast_zero = (src_a == '0) || (src_b == '0);
`else
  assign fast_zero = 1'b0;
`endif

  // acc[XLEN-1:0] is the multiplier shifting out during MUL and the
  // dividend/quotient shifting through during DIV.
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
  assign div_shift = {rem[XLEN-1:0], acc[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_mag};

  assign prod_fix  = neg_q ? -acc : acc;
  assign quo_fix   = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix   = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];

  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div   <= 1'b0;
      dz       <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'b100: hi <= src_a;
              3'b101: lo <= src_a;
              3'b000, 3'b001: begin
                a_mag  <= abs_a;
                b_mag  <= abs_b;
                neg_q  <= op_signed & (src_a[XLEN-1] ^ src_b[XLEN-1]);
                neg_r  <= 1'b0;
                is_div <= 1'b0;
                dz     <= 1'b0;
                rem    <= '0;
                count  <= '0;
                if (fast_zero) begin
                  acc   <= '0;
                  state <= FIX;
                end else begin
                  acc   <= {{XLEN{1'b0}}, abs_b};
                  state <= MUL;
                end
              end
              3'b010, 3'b011: begin
                a_mag  <= abs_a;
                b_mag  <= abs_b;
                neg_q  <= op_signed & (src_a[XLEN-1] ^ src_b[XLEN-1]);
                neg_r  <= op_signed & src_a[XLEN-1];
                is_div <= 1'b1;
                count  <= '0;
                acc    <= {{XLEN{1'b0}}, abs_a};
                // A zero divisor leaves the dividend as the remainder.
                if (src_b == '0) begin
                  dz    <= 1'b1;
                  rem   <= {1'b0, abs_a};
                  state <= FIX;
                end else begin
                  dz    <= 1'b0;
                  rem   <= '0;
                  state <= DIV;
                end
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc   <= {mul_sum, acc[XLEN-1:1]};
          count <= count + CW'(1);
          if (count == CW'(XLEN-1)) state <= FIX;
        end
        DIV: begin
          if (!div_diff[XLEN]) begin
            rem            <= div_diff;
            acc[XLEN-1:0]  <= {acc[XLEN-2:0], 1'b1};
          end else begin
            rem            <= div_shift;
            acc[XLEN-1:0]  <= {acc[XLEN-2:0], 1'b0};
          end
          count <= count + CW'(1);
          if (count == CW'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo       <= dz ? '1 : quo_fix;
            hi       <= rem_fix;
            div_zero <= dz;
          end else begin
            hi <= prod_fix[2*XLEN-1:XLEN];
            lo <= prod_fix[XLEN-1:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases from the arithmetic rules
// plus randomized back-to-back ops against a plain-arithmetic reference model.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {hi,lo}, divide-by-zero flag and edges from accept to done.
  function automatic void model(input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, output logic [63:0] e,
                                output bit dz, output int lat);
    int ia, ib;
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] q64, r64;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'b0, a}; ub = {32'b0, b};
    dz  = 1'b0;
    lat = 33;
    e   = '0;
    case (o)
      3'b000: e = sa * sb;
      3'b001: e = ua * ub;
      default: begin
        if (b == 0) begin
          e = {a, 32'hFFFF_FFFF};
          dz = 1'b1;
          lat = 1;
        end else begin
          if (o == 3'b010) begin
            sq = sa / sb; sr = sa % sb;
            q64 = sq; r64 = sr;
          end else begin
            q64 = ua / ub; r64 = ua % ub;
          end
          e = {r64[31:0], q64[31:0]};
        end
      end
    endcase
`ifdef MULDIV_FAST_ZERO_EN
    if (o[2:1] == 2'b00 && (a == 0 || b == 0)) lat = 1;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Driver: issue op at a falling edge, follow it to done, score it.
  // Returns on the falling edge where done is high so the next call can
  // start in that same cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit intrude, input string name);
    logic [63:0] e, got;
    bit edz;
    int lat, n, busy_n;
    model(o, a, b, e, edz, lat);
    exp_q.push_back(e);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    n = 0;
    busy_n = 0;
    while (!done && n < 60) begin
      if (busy) busy_n++;
      if (intrude && n == 4) begin
        start = 1'b1; op = 3'(($urandom_range(0, 3))); src_a = $urandom; src_b = $urandom;
      end else if (intrude && n == 5) begin
        start = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    got = {hi, lo};
    e = exp_q.pop_front();
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, n);
    end
    n_cmp++;
    if (n !== lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d edges, want %0d", name, n, lat);
    end
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s hilo: got %h_%h, want %h_%h", name, got[63:32], got[31:0], e[63:32], e[31:0]);
    end
    n_cmp++;
    if (div_zero !== edz) begin
      n_err++;
      $display("FAIL %s div_zero: got %b, want %b", name, div_zero, edz);
    end
    n_cmp++;
    if (busy_n !== lat || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy: high %0d cycles (busy now %b), want %0d then 0", name, busy_n, busy, lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, div_zero, hi, lo} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h, want all 0", busy, done, div_zero, hi, lo);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mt();
    int busy_seen;
    busy_seen = 0;
    start = 1'b1; op = 3'b100; src_a = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    busy_seen += busy;
    op = 3'b101; src_a = 32'h5678;
    @(posedge clk);
    @(negedge clk);
    busy_seen += busy;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    busy_seen += busy + done;
    n_cmp++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      n_err++;
      $display("FAIL mthi_mtlo: got hi=%h lo=%h, want 00001234 00005678", hi, lo);
    end
    n_cmp++;
    if (busy_seen != 0) begin
      n_err++;
      $display("FAIL mt_busy: busy/done seen %0d times, want 0", busy_seen);
    end
    // Reserved op must leave HI/LO untouched.
    start = 1'b1; op = 3'b110; src_a = 32'hDEAD_BEEF; src_b = 32'h1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reserved_op: got hi=%h lo=%h busy=%b, want 00001234 00005678 0", hi, lo, busy);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    done_seen = 0;
    start = 1'b1; op = 3'b000; src_a = 32'd6; src_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    do_reset();
    n_cmp++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got hi=%h lo=%h busy=%b, want 0 0 0", hi, lo, busy);
    end
    repeat (40) begin
      @(negedge clk);
      done_seen += done;
    end
    n_cmp++;
    if (done_seen != 0 || hi !== '0 || lo !== '0) begin
      n_err++;
      $display("FAIL reset_abandon: done seen %0d, hi=%h lo=%h, want 0 0 0", done_seen, hi, lo);
    end
  endtask

  task automatic test_directed();
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    n_cmp++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL multu_max_lit: got %h_%h, want fffffffe_00000001", hi, lo);
    end
    run_op(3'b000, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg");
    n_cmp++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      n_err++;
      $display("FAIL mult_neg_lit: got %h_%h, want ffffffff_ffffffeb", hi, lo);
    end
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
    n_cmp++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL div_neg_lit: got lo=%h hi=%h, want fffffffd ffffffff", lo, hi);
    end
    run_op(3'b011, 32'd100, 32'd7, 1'b0, "divu_100_7");
    n_cmp++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      n_err++;
      $display("FAIL divu_lit: got lo=%0d hi=%0d, want 14 2", lo, hi);
    end
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    n_cmp++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
      n_err++;
      $display("FAIL div_ovf_lit: got lo=%h hi=%h, want 80000000 00000000", lo, hi);
    end
  endtask

  task automatic test_div_zero();
    run_op(3'b010, 32'd5, 32'd0, 1'b0, "div_5_0");
    n_cmp++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin
      n_err++;
      $display("FAIL div_zero_lit: got lo=%h hi=%h, want ffffffff 00000005", lo, hi);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL pulse_width: got done=%b dz=%b busy=%b one cycle later, want 0 0 0", done, div_zero, busy);
    end
    run_op(3'b011, 32'h8000_0001, 32'd0, 1'b0, "divu_x_0");
    run_op(3'b010, 32'hFFFF_FF00, 32'd0, 1'b0, "div_neg_0");
  endtask

  task automatic test_busy_ignore();
    run_op(3'b000, 32'd1234567, 32'hFFFF_F000, 1'b1, "busy_ignore_mul");
    run_op(3'b010, 32'hFFFF_0001, 32'd33, 1'b1, "busy_ignore_div");
  endtask

  task automatic test_fast_zero();
    run_op(3'b000, 32'd0, 32'h55, 1'b0, "mult_zero");
    n_cmp++;
    if (hi !== '0 || lo !== '0) begin
      n_err++;
      $display("FAIL mult_zero_lit: got %h_%h, want 0", hi, lo);
    end
    run_op(3'b001, 32'h1234, 32'd0, 1'b0, "multu_zero");
  endtask

  // Back-to-back: each op is issued in the cycle its predecessor's done is high.
  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [2:0]  o;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: b = 32'hFFFF_FFFF;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      run_op(o, a, b, 1'b0, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_mt();
    test_reset_mid();
    test_directed();
    test_div_zero();
    test_busy_ignore();
    test_fast_zero();
    test_back_to_back();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
